// File: rtl/rv32m_muldiv_unit.sv
// RV32 M-extension execute unit: iterative shift-add multiply and restoring divide, UNROLL bits per CALC cycle.
// Build option: define RV32M_FAST_MUL_EN for a single-cycle combinational multiplier (divide stays iterative).
module rv32m_muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] operand1_in,
  input  logic [XLEN-1:0] operand2_in,
  input  logic            flush_in,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [XLEN-1:0] result_out,
  output logic            busy_out
);
  localparam int STEPS = XLEN / UNROLL;
  localparam int CNT_W = $clog2(STEPS + 1);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   opb_q;
  logic [XLEN-1:0]   result_q;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_quo_q, neg_rem_q;

  logic              accept_w, sgn1_w, sgn2_w, neg1_w, neg2_w;
  logic              div_zero_w, div_ovf_w, special_w;
  logic [XLEN-1:0]   mag1_w, mag2_w;
  logic [CNT_W-1:0]  cnt_init_w;

  assign accept_w = (state_q == IDLE) && valid_in && !flush_in;
  assign sgn1_w   = funct3_in inside {F_MULH, F_MULHSU, F_DIV, F_REM};
  assign sgn2_w   = funct3_in inside {F_MULH, F_DIV, F_REM};
  assign neg1_w   = sgn1_w && operand1_in[XLEN-1];
  assign neg2_w   = sgn2_w && operand2_in[XLEN-1];
  // Negating 100..0 yields 100..0, which read as unsigned is the correct magnitude.
  assign mag1_w   = neg1_w ? -operand1_in : operand1_in;
  assign mag2_w   = neg2_w ? -operand2_in : operand2_in;

  assign div_zero_w = funct3_in[2] && (operand2_in == '0);
  assign div_ovf_w  = sgn2_w && funct3_in[2] &&
                      (operand1_in == {1'b1, {(XLEN-1){1'b0}}}) && (operand2_in == '1);
  assign special_w  = div_zero_w || div_ovf_w;

`ifdef RV32M_FAST_MUL_EN
  assign cnt_init_w = funct3_in[2] ? CNT_W'(STEPS) : CNT_W'(1);
`else
  assign cnt_init_w = CNT_W'(STEPS);
`endif

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  logic [2*XLEN-1:0] step_w [UNROLL+1];
  assign step_w[0] = acc_q;

  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
    logic [XLEN:0] msum_w, dshift_w, ddiff_w;
    assign msum_w   = {1'b0, step_w[gi][2*XLEN-1:XLEN]} + (step_w[gi][0] ? {1'b0, opb_q} : '0);
    assign dshift_w = step_w[gi][2*XLEN-1:XLEN-1];
    assign ddiff_w  = dshift_w - {1'b0, opb_q};
    assign step_w[gi+1] = !funct3_q[2] ? {msum_w, step_w[gi][XLEN-1:1]} :
                          ddiff_w[XLEN] ? {dshift_w[XLEN-1:0], step_w[gi][XLEN-2:0], 1'b0} :
                                          {ddiff_w[XLEN-1:0], step_w[gi][XLEN-2:0], 1'b1};
  end

  always_comb begin
    acc_d = acc_q;
    if (accept_w) begin
      if (div_zero_w)     acc_d = {operand1_in, {XLEN{1'b1}}};
      else if (div_ovf_w) acc_d = {{XLEN{1'b0}}, operand1_in};
      else                acc_d = {{XLEN{1'b0}}, mag1_w};
    end else if (state_q == CALC) begin
`ifdef RV32M_FAST_MUL_EN
      acc_d = funct3_q[2] ? step_w[UNROLL]
                          : ({{XLEN{1'b0}}, acc_q[XLEN-1:0]} * {{XLEN{1'b0}}, opb_q});
`else
      acc_d = step_w[UNROLL];
`endif
    end
  end

  logic [2*XLEN-1:0] prod_w;
  logic [XLEN-1:0]   quo_w, rem_w, fix_res_w;

  always_comb begin
    prod_w = neg_quo_q ? -acc_q : acc_q;
    quo_w  = neg_quo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_w  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (funct3_q)
      F_MUL:                      fix_res_w = prod_w[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU:  fix_res_w = prod_w[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:              fix_res_w = quo_w;
      default:                    fix_res_w = rem_w;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept_w) state_d = special_w ? FIX : CALC;
      CALC: if (flush_in) state_d = IDLE;
            else if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:  state_d = flush_in ? IDLE : DONE;
      DONE: if (flush_in || ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_out  = (state_q == IDLE);
    busy_out   = (state_q != IDLE);
    valid_out  = (state_q == DONE);
    result_out = result_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      funct3_q  <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      acc_q <= acc_d;
      if (accept_w) begin
        funct3_q  <= funct3_in;
        opb_q     <= mag2_w;
        cnt_q     <= cnt_init_w;
        neg_quo_q <= !special_w && (neg1_w ^ neg2_w);
        neg_rem_q <= !special_w && funct3_in[2] && neg1_w;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (state_q == FIX && !flush_in) result_q <= fix_res_w;
    end
  end
endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Scoreboard bench for rv32m_muldiv_unit: default 32-bit instance plus a 16-bit, UNROLL=4 instance,
// both checked against plain-arithmetic RISC-V M semantics.
module tb_rv32m_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_in = 1'b0, flush_in = 1'b0, ready_in = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op1 = '0, op2 = '0;
  logic        ready_out, valid_out, busy_out;
  logic [31:0] result_out;

  logic        b_valid_in = 1'b0;
  logic [2:0]  b_funct3 = '0;
  logic [15:0] b_op1 = '0, b_op2 = '0;
  logic        b_ready_out, b_valid_out, b_busy_out;
  logic [15:0] b_result_out;

  int n_cmp = 0, n_bad = 0, cyc = 0, rdy_mode = 1;
  bit rst_done = 0, b_done = 0, seen = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b, res;
    int          lat, acc;
  } exp_t;
  exp_t exp_q[$];

  rv32m_muldiv_unit #(.XLEN(32), .UNROLL(1)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_out(ready_out),
    .funct3_in(funct3), .operand1_in(op1), .operand2_in(op2), .flush_in(flush_in),
    .valid_out(valid_out), .ready_in(ready_in), .result_out(result_out), .busy_out(busy_out));

  rv32m_muldiv_unit #(.XLEN(16), .UNROLL(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .valid_in(b_valid_in), .ready_out(b_ready_out),
    .funct3_in(b_funct3), .operand1_in(b_op1), .operand2_in(b_op2), .flush_in(1'b0),
    .valid_out(b_valid_out), .ready_in(1'b1), .result_out(b_result_out), .busy_out(b_busy_out));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (rdy_mode == 0)      ready_in = 1'b0;
    else if (rdy_mode == 1) ready_in = 1'b1;
    else                    ready_in = ($urandom_range(0, 2) != 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic longint sx(input longint u, input int w);
    return (((u >> (w - 1)) & 1) != 0) ? u - (longint'(1) << w) : u;
  endfunction

  // Reference semantics of the eight M ops for a w-bit datapath.
  function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a, b, input int w);
    longint mask, ua, ub, sa, sb, r;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = sx(ua, w);
    sb = sx(ub, w);
    case (f3)
      3'd0: r = ua * ub;
      3'd1: r = (sa * sb) >>> w;
      3'd2: r = (sa * ub) >>> w;
      3'd3: r = (ua * ub) >> w;
      3'd4: r = (ub == 0) ? -1 : sa / sb;
      3'd5: r = (ub == 0) ? -1 : ua / ub;
      3'd6: r = (ub == 0) ? sa : sa % sb;
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return 32'(r & mask);
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, b, input int w, input int unroll);
    longint mask, ua, ub;
    bit special;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    special = (f3[2] && ub == 0) ||
              ((f3 == 3'd4 || f3 == 3'd6) && sx(ua, w) == -(longint'(1) << (w - 1)) && sx(ub, w) == -1);
`ifdef RV32M_FAST_MUL_EN
    if (!f3[2]) return 2;
`endif
    return special ? 1 : w / unroll + 1;
  endfunction

  function automatic logic [31:0] pick(input int w);
    longint mask;
    mask = (longint'(1) << w) - 1;
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'(mask);
      3: return 32'(longint'(1) << (w - 1));
      4: return 32'($urandom_range(0, 15));
      default: return 32'(longint'($urandom) & mask);
    endcase
  endfunction

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual=timeout required=event", name);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, b, input bit track);
    exp_t e;
    @(negedge clk);
    funct3 = f3; op1 = a; op2 = b; valid_in = 1'b1;
    for (int i = 0; i < 400 && !ready_out; i++) @(negedge clk);
    if (!ready_out) begin
      fail_now("accept_timeout");
      valid_in = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    if (track) begin
      e.f3 = f3; e.a = a; e.b = b;
      e.res = model_res(f3, a, b, 32);
      e.lat = model_lat(f3, a, b, 32, 1);
      e.acc = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
      seen = 0;
    end
  endtask

  // Monitor: compares every result presented by the 32-bit instance against the queue head.
  always @(negedge clk) begin
    if (reset_n && valid_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(valid_out), 32'd0);
      end else begin
        if (!seen) begin
          check("result", result_out, exp_q[0].res);
          check("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
          seen = 1;
        end else begin
          check("held_result", result_out, exp_q[0].res);
        end
        if (ready_in) begin
          $display("txn A f3=%0d a=%h b=%h res=%h lat=%0d", exp_q[0].f3, exp_q[0].a, exp_q[0].b,
                   result_out, cyc - exp_q[0].acc);
          void'(exp_q.pop_front());
          seen = 0;
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    valid_in = 1'b1;
    funct3 = 3'd0; op1 = 32'd5; op2 = 32'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready_out", 32'(ready_out), 32'd1);
    check("rst_busy_out", 32'(busy_out), 32'd0);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_result_out", result_out, 32'd0);
    valid_in = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy_out), 32'd0);
    check("post_rst_ready", 32'(ready_out), 32'd1);
    rst_done = 1;

    // flush wins over a request in IDLE
    funct3 = 3'd4; op1 = 32'd50; op2 = 32'd5; valid_in = 1'b1; flush_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0; flush_in = 1'b0;
    @(negedge clk);
    check("idle_flush_busy", 32'(busy_out), 32'd0);

    rdy_mode = 1;
    for (int f = 0; f < 4; f++) issue(3'(f), 32'hFFFFFFFF, 32'h00000003, 1);
    for (int f = 4; f < 8; f++) issue(3'(f), 32'hFFFFFFF9, 32'h00000002, 1);
    issue(3'd4, 32'h00001234, 32'h0, 1);
    issue(3'd7, 32'h00001234, 32'h0, 1);
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 1);
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 1);
    issue(3'd5, 32'h80000000, 32'hFFFFFFFF, 1);
    drain();

    // backpressure: result held, unit not ready
    rdy_mode = 0;
    issue(3'd1, 32'h87654321, 32'h12345678, 1);
    for (int i = 0; i < 100 && !valid_out; i++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("bp_ready_out", 32'(ready_out), 32'd0);
      check("bp_valid_out", 32'(valid_out), 32'd1);
    end
    rdy_mode = 1;
    drain();

    // flush on the tenth CALC edge
    issue(3'd4, 32'h12345678, 32'd3, 0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_in = 1'b1;
    @(posedge clk);
    #1;
    flush_in = 1'b0;
    @(negedge clk);
    check("flush_ready_out", 32'(ready_out), 32'd1);
    check("flush_valid_out", 32'(valid_out), 32'd0);
    repeat (40) @(negedge clk);
    issue(3'd5, 32'd100, 32'd7, 1);
    drain();

    rdy_mode = 2;
    for (int k = 0; k < 40; k++) issue(3'($urandom_range(0, 7)), pick(32), pick(32), 1);
    drain();
    rdy_mode = 1;

    for (int i = 0; i < 20000 && !b_done; i++) @(negedge clk);
    if (!b_done) fail_now("b_done_timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // 16-bit, UNROLL=4 instance: one transaction at a time.
  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          acc;
    wait (rst_done);
    for (int k = 0; k < 25; k++) begin
      f3 = (k == 0) ? 3'd3 : 3'($urandom_range(0, 7));
      a  = (k == 0) ? 32'h0000FFFF : pick(16);
      b  = (k == 0) ? 32'h0000FFFF : pick(16);
      @(negedge clk);
      b_funct3 = f3; b_op1 = a[15:0]; b_op2 = b[15:0]; b_valid_in = 1'b1;
      for (int i = 0; i < 50 && !b_ready_out; i++) @(negedge clk);
      @(posedge clk);
      #1;
      acc = cyc;
      b_valid_in = 1'b0;
      for (int i = 0; i < 50 && !b_valid_out; i++) @(negedge clk);
      check("b_result", 32'(b_result_out), model_res(f3, a, b, 16));
      check("b_latency", 32'(cyc - acc), 32'(model_lat(f3, a, b, 16, 4)));
      $display("txn B f3=%0d a=%h b=%h res=%h lat=%0d", f3, a[15:0], b[15:0], b_result_out, cyc - acc);
      @(negedge clk);
    end
    check("b_idle_busy", 32'(b_busy_out), 32'd0);
    b_done = 1;
  end
endmodule
